// File: rtl/condicionador_entrada_pkg.sv
// Shared definitions for the combination-lock input conditioning path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lock_pkg;

  // Debounce FSM states; all four encodings are assigned.
  typedef enum logic [1:0] {
    SOLTO          = 2'b00,
    CONFIRMA_PRESS = 2'b01,
    PRESSIONADO    = 2'b10,
    CONFIRMA_SOLTA = 2'b11
  } estado_t;

  // Largest digit the lock accepts.
  localparam int DIGITO_MAX = 9;

  // 10 ms at 50 MHz.
  localparam int DEBOUNCE_CICLOS_PADRAO = 500000;

  // True when a captured switch value is not a decimal digit.
  function automatic logic digito_fora(input logic [3:0] d);
    return d > 4'(DIGITO_MAX);
  endfunction

endpackage

// File: rtl/condicionador_entrada_if.sv
// Raw key/switch inputs and conditioned outputs of the input stage.
// Latency: n/a (signal bundle).
// Backpressure: none; outputs are levels and a strobe.
interface condicionador_entrada_if;
  logic       insere_bruto;
  logic [4:1] numero_bruto;
  logic       insere_limpo;
  logic       insere_pulso;
  logic [4:1] numero;
  logic       digito_invalido;
  logic [2:0] contador_press;

  // master drives the raw inputs and observes the clean outputs
  modport master (
    output insere_bruto, numero_bruto,
    input  insere_limpo, insere_pulso, numero, digito_invalido, contador_press
  );

  // slave is the conditioning stage itself
  modport slave (
    input  insere_bruto, numero_bruto,
    output insere_limpo, insere_pulso, numero, digito_invalido, contador_press
  );
endinterface

// File: rtl/condicionador_entrada_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous inputs, parameterised width/reset value.
// Latency: 2 clk cycles.
// Backpressure: none.
module sincronizador_2ff #(
  parameter int             LARG      = 1,
  parameter logic [LARG-1:0] VAL_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [LARG-1:0] d,
  output logic [LARG-1:0] q
);

  logic [LARG-1:0] meta;

  // First flop may go metastable; second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= VAL_RESET;
      q    <= VAL_RESET;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/condicionador_entrada.sv
// Synchronises and debounces the key, captures the digit on each confirmed press.
// Latency: 2 sync cycles + DEBOUNCE_CICLOS (+1) from key edge to insere_limpo.
// Backpressure: none; insere_pulso is a one-cycle strobe that cannot be stalled.
module condicionador_entrada
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int CONT_LARG       = 20
) (
  input logic                    clk,
  input logic                    reset,
  condicionador_entrada_if.slave io
);

  localparam logic [CONT_LARG-1:0] CONT_FIM = CONT_LARG'(DEBOUNCE_CICLOS - 1);

  logic                 ins_s;
  logic [4:1]           num_s;
  estado_t              estado;
  logic [CONT_LARG-1:0] cont;

  // Key idles released (1), so its synchroniser resets to 1.
  sincronizador_2ff #(.LARG(1), .VAL_RESET(1'b1)) u_sinc_insere (
    .clk   (clk),
    .reset (reset),
    .d     (io.insere_bruto),
    .q     (ins_s)
  );

  sincronizador_2ff #(.LARG(4), .VAL_RESET(4'h0)) u_sinc_numero (
    .clk   (clk),
    .reset (reset),
    .d     (io.numero_bruto),
    .q     (num_s)
  );

  // Debounce FSM with registered outputs; the digit is sampled only when a press is confirmed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado             <= SOLTO;
      cont               <= '0;
      io.insere_limpo    <= 1'b1;
      io.insere_pulso    <= 1'b0;
      io.numero          <= '0;
      io.digito_invalido <= 1'b0;
      io.contador_press  <= '0;
    end else begin
      io.insere_pulso <= 1'b0;
      case (estado)
        SOLTO: begin
          if (!ins_s) begin
            cont   <= '0;
            estado <= CONFIRMA_PRESS;
          end
        end
        CONFIRMA_PRESS: begin
          if (ins_s) begin
            estado <= SOLTO;
          end else if (cont == CONT_FIM) begin
            estado             <= PRESSIONADO;
            io.numero          <= num_s;
            io.digito_invalido <= digito_fora(num_s);
            io.insere_limpo    <= 1'b0;
            io.insere_pulso    <= 1'b1;
            if (io.contador_press != 3'd7)
              io.contador_press <= io.contador_press + 3'd1;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        PRESSIONADO: begin
          if (ins_s) begin
            cont   <= '0;
            estado <= CONFIRMA_SOLTA;
          end
        end
        CONFIRMA_SOLTA: begin
          if (!ins_s) begin
            estado <= PRESSIONADO;
          end else if (cont == CONT_FIM) begin
            estado          <= SOLTO;
            io.insere_limpo <= 1'b1;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        default: estado <= SOLTO;
      endcase
    end
  end

endmodule

// File: tb/tb_condicionador_entrada.sv
module tb_condicionador_entrada;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  condicionador_entrada_if bus ();

  condicionador_entrada #(.DEBOUNCE_CICLOS(DEB), .CONT_LARG(20)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulsos   = 0;
  bit cmp_en   = 1'b0;

  // Model: the clean level flips once the synchronised key has disagreed
  // with it for DEB+1 consecutive clock edges.
  bit         m_limpo = 1'b1;
  bit         m_pulso = 1'b0;
  bit         m_inv   = 1'b0;
  logic [3:0] m_num   = '0;
  int         m_cnt   = 0;
  int         m_run   = 0;
  logic       h1 = 1'b1, h2 = 1'b1;
  logic [3:0] n1 = '0, n2 = '0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_limpo = 1'b1; m_pulso = 1'b0; m_inv = 1'b0; m_num = '0;
        m_cnt = 0; m_run = 0; h1 = 1'b1; h2 = 1'b1; n1 = '0; n2 = '0;
      end else begin
        m_pulso = 1'b0;
        if (h2 != m_limpo) begin
          m_run++;
          if (m_run == DEB + 1) begin
            m_limpo = h2;
            m_run   = 0;
            if (!h2) begin
              m_pulso = 1'b1;
              m_num   = n2;
              m_inv   = (n2 > 4'd9);
              if (m_cnt < 7) m_cnt++;
            end
          end
        end else begin
          m_run = 0;
        end
        h2 = h1; h1 = bus.insere_bruto;
        n2 = n1; n1 = bus.numero_bruto;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("model_insere_limpo", int'(bus.insere_limpo), int'(m_limpo));
        chk("model_insere_pulso", int'(bus.insere_pulso), int'(m_pulso));
        chk("model_numero", int'(bus.numero), int'(m_num));
        chk("model_digito_invalido", int'(bus.digito_invalido), int'(m_inv));
        chk("model_contador_press", int'(bus.contador_press), m_cnt);
        if (bus.insere_pulso) pulsos++;
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic aperta(input logic [3:0] d, input int baixo, input int alto);
    bus.numero_bruto = d;
    bus.insere_bruto = 1'b0;
    ciclos(baixo);
    bus.insere_bruto = 1'b1;
    ciclos(alto);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_insere_limpo"}, int'(bus.insere_limpo), 1);
    chk({nm, "_insere_pulso"}, int'(bus.insere_pulso), 0);
    chk({nm, "_numero"}, int'(bus.numero), 0);
    chk({nm, "_digito_invalido"}, int'(bus.digito_invalido), 0);
    chk({nm, "_contador_press"}, int'(bus.contador_press), 0);
  endtask

  initial begin
    int p0;
    bus.insere_bruto = 1'b1;
    bus.numero_bruto = 4'h0;
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // Reset with random raw inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.insere_bruto = 1'($urandom_range(0, 1));
      bus.numero_bruto = 4'($urandom_range(0, 15));
    end
    #1 chk_reset("reset");
    @(negedge clk);
    bus.insere_bruto = 1'b1;
    bus.numero_bruto = 4'h0;
    reset = 1'b1;
    ciclos(10);
    chk_reset("idle");

    // Bounces shorter than the debounce window.
    p0 = pulsos;
    for (int i = 0; i < 5; i++) begin
      bus.insere_bruto = 1'b0; ciclos(2);
      bus.insere_bruto = 1'b1; ciclos(2);
    end
    ciclos(10);
    chk("bounce_pulses", pulsos - p0, 0);
    chk("bounce_limpo", int'(bus.insere_limpo), 1);
    chk("bounce_cnt", int'(bus.contador_press), 0);

    // Clean press with digit 5.
    p0 = pulsos;
    aperta(4'd5, 10, 0);
    chk("press5_pulses", pulsos - p0, 1);
    chk("press5_limpo", int'(bus.insere_limpo), 0);
    chk("press5_numero", int'(bus.numero), 5);
    chk("press5_inv", int'(bus.digito_invalido), 0);
    chk("press5_cnt", int'(bus.contador_press), 1);
    ciclos(10);
    chk("release5_limpo", int'(bus.insere_limpo), 1);

    // Switch change while held is ignored.
    bus.numero_bruto = 4'd9;
    bus.insere_bruto = 1'b0;
    ciclos(10);
    bus.numero_bruto = 4'd3;
    ciclos(6);
    chk("held9_numero", int'(bus.numero), 9);
    bus.insere_bruto = 1'b1;
    ciclos(10);
    chk("released9_numero", int'(bus.numero), 9);

    // Invalid digit then valid digit.
    aperta(4'd12, 10, 10);
    chk("press12_numero", int'(bus.numero), 12);
    chk("press12_inv", int'(bus.digito_invalido), 1);
    aperta(4'd0, 10, 10);
    chk("press0_inv", int'(bus.digito_invalido), 0);
    chk("press0_numero", int'(bus.numero), 0);

    // Presses 5..8, then the 9th with reset asserted mid-press.
    for (int i = 0; i < 4; i++) aperta(4'(i + 1), 10, 10);
    chk("sat_cnt8", int'(bus.contador_press), 7);
    p0 = pulsos;
    bus.numero_bruto = 4'd7;
    bus.insere_bruto = 1'b0;
    ciclos(8);
    chk("sat_cnt9", int'(bus.contador_press), 7);
    chk("press9_pulses", pulsos - p0, 1);
    chk("press9_limpo", int'(bus.insere_limpo), 0);
    #2 reset = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    reset = 1'b1;
    ciclos(12);
    chk("repress_limpo", int'(bus.insere_limpo), 0);
    chk("repress_cnt", int'(bus.contador_press), 1);
    chk("repress_numero", int'(bus.numero), 7);
    bus.insere_bruto = 1'b1;
    ciclos(10);
    chk("final_limpo", int'(bus.insere_limpo), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/condicionador_entrada.md
Name: condicionador_entrada

Overview:
Input-conditioning stage that sits directly upstream of the combination-lock FSM.
- Synchronises the raw push-button (insere) and the 4 digit switches (numero) to clk.
- Debounces the button and captures the digit at the instant a press is confirmed.
- Delivers a clean active-low insere level, a one-cycle press strobe and a stable registered digit, so the lock never sees bounces or switch changes mid-press.
- Flags digits greater than 9 so the display and lock stages can reject them.

Parameters:
DEBOUNCE_CICLOS, 500000, consecutive stable clk cycles required to accept a button level change (10 ms at 50 MHz); legal range 2..2^20-1.
CONT_LARG, 20, width of the debounce counter; must satisfy 2^CONT_LARG > DEBOUNCE_CICLOS.

Ports:
clk  input  1  system clock, all logic rising-edge.
reset  input  1  asynchronous, active-low reset; all state is cleared immediately while reset=0.
insere_bruto  input  1  raw key, active-low (0 = pressed), asynchronous and bouncy.
numero_bruto  input  4 [4:1]  raw digit switches, asynchronous.
insere_limpo  output  1  debounced key level, active-low; feeds the lock's insere input.
insere_pulso  output  1  one-cycle high strobe on each confirmed press.
numero  output  4 [4:1]  digit captured at the last confirmed press; held stable until the next press.
digito_invalido  output  1  high when the captured numero > 9; valid with numero.
contador_press  output  3  saturating count of confirmed presses since reset (0..7).

Behaviour:
- Synchronisers:
  - 2-flop synchroniser on insere_bruto, reset value 1.
  - 2-flop synchroniser on each numero_bruto bit, reset value 0.
  - All downstream logic uses only the synchronised values (ins_s, num_s).
- Reset values: insere_limpo=1, insere_pulso=0, numero=0, digito_invalido=0, contador_press=0, FSM=SOLTO, counter=0.
- Debounce FSM states:
  - SOLTO: stable released. If ins_s=0, clear counter and go to CONFIRMA_PRESS.
  - CONFIRMA_PRESS: if ins_s=1, go to SOLTO (bounce rejected, no outputs change). Otherwise increment the counter. When the counter reaches DEBOUNCE_CICLOS-1 with ins_s still 0, go to PRESSIONADO.
  - PRESSIONADO: stable pressed. If ins_s=1, clear counter and go to CONFIRMA_SOLTA.
  - CONFIRMA_SOLTA: if ins_s=0, go to PRESSIONADO. Otherwise increment the counter. When the counter reaches DEBOUNCE_CICLOS-1 with ins_s still 1, go to SOLTO.
- Transition CONFIRMA_PRESS->PRESSIONADO: in the same clock edge, register numero<=num_s, digito_invalido<=(num_s>9), insere_limpo<=0 and insere_pulso<=1. contador_press increments and saturates at 7.
- Transition CONFIRMA_SOLTA->SOLTO: insere_limpo<=1. numero and digito_invalido are unchanged.
- insere_pulso is high for exactly one cycle per confirmed press, in the cycle in which insere_limpo first reads 0.
- Latency: from a clean falling edge of insere_bruto to insere_limpo=0 is 2 sync cycles + DEBOUNCE_CICLOS cycles (±1). Release latency is identical.
- Switch changes on numero_bruto while PRESSIONADO or SOLTO have no effect on numero. Digits are sampled only at press confirmation.
- A bounce shorter than DEBOUNCE_CICLOS in either confirm state produces no output change and no strobe.
- Counter width: CONT_LARG bits. The counter never wraps because the FSM leaves the confirm state at DEBOUNCE_CICLOS-1.
- contador_press holds at 7 on further presses.
- Reset asserted mid-press: everything returns to reset values asynchronously. After reset deasserts with the key still held, the key is treated as a new press and confirmed after the debounce time.
- Unused FSM encodings return to SOLTO.

Decomposition:
- Shared package (lock_pkg):
  - FSM state encodings SOLTO/CONFIRMA_PRESS/PRESSIONADO/CONFIRMA_SOLTA.
  - Constant DIGITO_MAX=9.
  - Default DEBOUNCE_CICLOS.
- One natural sub-module: sincronizador_2ff, parameterised width and reset value. It is instantiated twice: width 1 with reset value 1 for the key, width 4 with reset value 0 for the digit.

Test Plan:
All scenarios run with DEBOUNCE_CICLOS=4.
- reset=0 with random raw inputs -> insere_limpo=1, insere_pulso=0, numero=0, digito_invalido=0, contador_press=0; after release, outputs stay stable with the key idle.
- numero_bruto=5, insere_bruto held 0 for 10 cycles -> exactly one insere_pulso cycle, insere_limpo=0, numero=5, digito_invalido=0, contador_press=1; release for 10 cycles -> insere_limpo=1.
- insere_bruto toggled 0/1 every 2 cycles for 20 cycles, then held 1 -> no insere_pulso, insere_limpo stays 1, contador_press=0.
- Press with numero_bruto=9, change numero_bruto to 3 while held -> numero stays 9 until the next press.
- Press with numero_bruto=12 -> numero=12, digito_invalido=1; next press with numero_bruto=0 -> digito_invalido=0.
- Nine clean presses -> contador_press saturates at 7; assert reset during the 9th press -> all outputs return to reset values immediately, without waiting for a clk edge.
